// File: rtl/cnn_layer_sequencer.sv
// Sequences one CNN inference run through conv1, conv2 and fc engines,
// with a per-layer watchdog, abort/error handling and a run-length counter.
module cnn_layer_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        begin_conv1,
  input  logic        done_conv1,
  output logic        begin_conv2,
  input  logic        done_conv2,
  output logic        begin_fc,
  input  logic        done_fc,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        error,
  output logic [1:0]  layer,
  output logic [15:0] cycle_count
);

  // state    | meaning
  // IDLE     | waiting for start
  // C1_START | pulse begin_conv1
  // C1_WAIT  | waiting for done_conv1 (watchdog running)
  // C2_START | pulse begin_conv2
  // C2_WAIT  | waiting for done_conv2 (watchdog running)
  // FC_START | pulse begin_fc
  // FC_WAIT  | waiting for done_fc (watchdog running)
  // RESULT   | result_valid held until result_ready
  // ERR      | watchdog expired; held until abort
  typedef enum logic [3:0] {
    S_IDLE, S_C1_START, S_C1_WAIT, S_C2_START, S_C2_WAIT,
    S_FC_START, S_FC_WAIT, S_RESULT, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] wd_cnt, run_cnt, run_inc;
  logic        in_wait, in_run, done_hit, wd_expire;

  always_comb begin
    in_wait   = (state == S_C1_WAIT) || (state == S_C2_WAIT) || (state == S_FC_WAIT);
    in_run    = (state != S_IDLE) && (state != S_RESULT) && (state != S_ERR);
    done_hit  = ((state == S_C1_WAIT) && done_conv1) ||
                ((state == S_C2_WAIT) && done_conv2) ||
                ((state == S_FC_WAIT) && done_fc);
    // Expiry is judged on the count this cycle would produce; done wins a tie.
    wd_expire = in_wait && !done_hit && (({1'b0, wd_cnt} + 17'd1) == {1'b0, TIMEOUT});
    run_inc   = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;

    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_C1_START;
      S_C1_START: state_nxt = S_C1_WAIT;
      S_C1_WAIT:  if (done_hit) state_nxt = S_C2_START; else if (wd_expire) state_nxt = S_ERR;
      S_C2_START: state_nxt = S_C2_WAIT;
      S_C2_WAIT:  if (done_hit) state_nxt = S_FC_START; else if (wd_expire) state_nxt = S_ERR;
      S_FC_START: state_nxt = S_FC_WAIT;
      S_FC_WAIT:  if (done_hit) state_nxt = S_RESULT; else if (wd_expire) state_nxt = S_ERR;
      S_RESULT:   if (result_ready) state_nxt = S_IDLE;
      S_ERR:      state_nxt = S_ERR;
      default:    state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      begin_conv1  <= 1'b0;
      begin_conv2  <= 1'b0;
      begin_fc     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      layer        <= 2'd0;
      cycle_count  <= 16'd0;
      wd_cnt       <= 16'd0;
      run_cnt      <= 16'd0;
    end else begin
      state        <= state_nxt;
      begin_conv1  <= (state_nxt == S_C1_START);
      begin_conv2  <= (state_nxt == S_C2_START);
      begin_fc     <= (state_nxt == S_FC_START);
      result_valid <= (state_nxt == S_RESULT);
      busy         <= (state_nxt != S_IDLE);
      error        <= (state_nxt == S_ERR);
      case (state_nxt)
        S_C1_START, S_C1_WAIT: layer <= 2'd1;
        S_C2_START, S_C2_WAIT: layer <= 2'd2;
        S_FC_START, S_FC_WAIT: layer <= 2'd3;
        S_ERR:                 layer <= layer;
        default:               layer <= 2'd0;
      endcase
      wd_cnt  <= (in_wait && (state_nxt == state)) ? wd_cnt + 16'd1 : 16'd0;
      run_cnt <= in_run ? run_inc : 16'd0;
      // The FC_WAIT cycle that sees done_fc is itself part of the run.
      if ((state == S_FC_WAIT) && (state_nxt == S_RESULT)) cycle_count <= run_inc;
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer; begin pulses and results are
// checked against a scoreboard of expected events filled as runs are launched.
module tb_cnn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, done_conv1, done_conv2, done_fc, result_ready;
  logic        begin_conv1, begin_conv2, begin_fc, result_valid, busy, error;
  logic [1:0]  layer;
  logic [15:0] cycle_count;

  int n_cmp = 0;
  int n_fail = 0;
  logic [19:0] exp_q[$];
  logic        rv_q = 1'b0;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(.TIMEOUT(16'd4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .begin_conv1(begin_conv1), .done_conv1(done_conv1),
    .begin_conv2(begin_conv2), .done_conv2(done_conv2),
    .begin_fc(begin_fc), .done_fc(done_fc),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .error(error), .layer(layer), .cycle_count(cycle_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".outs"}, {26'd0, begin_conv1, begin_conv2, begin_fc, result_valid, busy, error}, 32'd0);
    chk({tag, ".layer"}, {30'd0, layer}, 32'd0);
  endtask

  // Event codes: 1 begin_conv1, 2 begin_conv2, 3 begin_fc, 4 result (with cycle_count).
  always @(negedge clk) begin
    logic [19:0] obs, exp;
    if (begin_conv1 || begin_conv2 || begin_fc || (result_valid && !rv_q)) begin
      if (begin_conv1)      obs = {4'd1, 16'd0};
      else if (begin_conv2) obs = {4'd2, 16'd0};
      else if (begin_fc)    obs = {4'd3, 16'd0};
      else                  obs = {4'd4, cycle_count};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
      n_cmp++;
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL event: observed %0h expected %0h", obs, exp);
      end
    end
    rv_q = result_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    rst_n = 0; start = 0; abort = 0; result_ready = 0;
    done_conv1 = 0; done_conv2 = 0; done_fc = 0;
    step(2);
    chk_idle_reset("reset");
    chk("reset.cc", {16'd0, cycle_count}, 32'd0);
    rst_n = 1;
    step(2);
    chk_idle_reset("post_reset");

    // Normal run, each done in the 3rd WAIT cycle, then backpressure.
    exp_q.push_back({4'd1, 16'd0}); exp_q.push_back({4'd2, 16'd0});
    exp_q.push_back({4'd3, 16'd0}); exp_q.push_back({4'd4, 16'd12});
    start = 1; step(1); start = 0;
    chk("run1.layer1", {30'd0, layer}, 32'd1);
    step(3); done_conv1 = 1; step(1); done_conv1 = 0;
    chk("run1.layer2", {30'd0, layer}, 32'd2);
    step(3); done_conv2 = 1; step(1); done_conv2 = 0;
    chk("run1.layer3", {30'd0, layer}, 32'd3);
    step(3); done_fc = 1; step(1); done_fc = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid_busy", {30'd0, result_valid, busy}, 32'd3);
      chk("bp.layer", {30'd0, layer}, 32'd0);
      step(1);
    end
    chk("run1.cc", {16'd0, cycle_count}, 32'd12);
    result_ready = 1; step(1); result_ready = 0;
    chk_idle_reset("bp.idle");

    // Stray inputs in C1_WAIT, quick conv2, done/timeout tie in FC_WAIT.
    exp_q.push_back({4'd1, 16'd0}); exp_q.push_back({4'd2, 16'd0});
    exp_q.push_back({4'd3, 16'd0}); exp_q.push_back({4'd4, 16'd11});
    start = 1; step(1); start = 0;
    step(1); done_fc = 1; start = 1; result_ready = 1;
    step(1); done_fc = 0; start = 0; result_ready = 0; done_conv2 = 1;
    chk("stray.layer_a", {30'd0, layer}, 32'd1);
    step(1); done_conv2 = 0;
    chk("stray.layer_b", {30'd0, layer, busy}, 32'd3);
    done_conv1 = 1; step(1); done_conv1 = 0;
    step(1); done_conv2 = 1; step(1); done_conv2 = 0;
    step(4); done_fc = 1; step(1); done_fc = 0;
    chk("tie.result", {31'd0, result_valid}, 32'd1);
    chk("tie.error", {31'd0, error}, 32'd0);
    chk("run2.cc", {16'd0, cycle_count}, 32'd11);

    // Start held through RESULT->IDLE launches a new run; then abort races done_conv1.
    result_ready = 1; start = 1;
    exp_q.push_back({4'd1, 16'd0});
    step(1);
    chk("held.idle", {31'd0, busy}, 32'd0);
    step(1); start = 0; result_ready = 0;
    chk("held.restart", {30'd0, layer}, 32'd1);
    step(2); abort = 1; done_conv1 = 1;
    step(1); abort = 0; done_conv1 = 0;
    chk_idle_reset("abort");
    chk("abort.cc", {16'd0, cycle_count}, 32'd11);
    step(3);
    chk_idle_reset("abort.quiet");

    // Watchdog: done_conv2 never arrives with TIMEOUT=4.
    exp_q.push_back({4'd1, 16'd0}); exp_q.push_back({4'd2, 16'd0});
    start = 1; step(1); start = 0;
    step(1); done_conv1 = 1; step(1); done_conv1 = 0;
    step(1);
    step(3);
    chk("wd.before", {30'd0, error, layer[1]}, 32'd1);
    step(1);
    chk("wd.error", {29'd0, error, layer}, 32'd6);
    start = 1; step(2); start = 0;
    chk("wd.held", {28'd0, error, busy, layer}, 32'hE);
    abort = 1; step(1); abort = 0;
    chk_idle_reset("wd.abort");
    chk("wd.cc", {16'd0, cycle_count}, 32'd11);

    // Reset asserted (together with abort) in FC_WAIT.
    exp_q.push_back({4'd1, 16'd0}); exp_q.push_back({4'd2, 16'd0});
    exp_q.push_back({4'd3, 16'd0});
    start = 1; step(1); start = 0;
    step(1); done_conv1 = 1; step(1); done_conv1 = 0;
    step(1); done_conv2 = 1; step(1); done_conv2 = 0;
    step(1);
    chk("rst.fc_wait", {30'd0, layer}, 32'd3);
    rst_n = 0; abort = 1; step(1); rst_n = 1; abort = 0;
    chk_idle_reset("rst.mid");
    chk("rst.cc", {16'd0, cycle_count}, 32'd0);
    step(3);
    chk_idle_reset("rst.quiet");
    chk("sb.empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
